weight_fill_sequencer: RTL and testbench
========================================

Name: weight_fill_sequencer

Overview:
Multi-tile successor to the single-shot weight-memory-to-FIFO fill controller. On a start pulse it issues per-column weight memory reads for one or more weight tiles back-to-back. Each tile base address is base_addr + tile*tile_stride. It also produces a latency-aligned fifo_active data-valid strobe for fifo_control. Sits between the top-level master control and the per-column weight memories / weight FIFOs feeding the systolic array.

Parameters:
SYS_ARR_ROWS, 16, systolic array rows; sets the row counter width.
SYS_ARR_COLS, 16, systolic array columns (one read port per column).
ADDR_WIDTH, 8, weight memory address width.
TILE_WIDTH, 4, width of num_tiles (up to 2^TILE_WIDTH tiles).
MEM_LAT, 1, weight memory read latency in cycles (>=1).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
abort  in  1  synchronous cancel of a sequence in progress.
num_row  in  $clog2(SYS_ARR_ROWS)  rows per tile minus 1.
num_col  in  $clog2(SYS_ARR_COLS)  active columns minus 1.
num_tiles  in  TILE_WIDTH  tiles minus 1.
base_addr  in  ADDR_WIDTH  address of tile 0, row 0.
tile_stride  in  ADDR_WIDTH  address increment between tiles.
weightMem_rd_en  out  SYS_ARR_COLS  per-column read enable.
weightMem_rd_addr  out  SYS_ARR_COLS*ADDR_WIDTH  per-column address; column c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH].
fifo_active  out  1  read data valid at FIFO inputs this cycle.
busy  out  1  high from the cycle after start acceptance until done.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0. Counters, captured config and delay lines cleared. Reset asserted mid-sequence aborts immediately; no done pulse.
- Timing origin: start high in IDLE at edge 0 is accepted. num_row, num_col, num_tiles, base_addr and tile_stride are captured. Later input changes are ignored until the next start.
- States:
  - IDLE -> READ on start.
  - READ -> DRAIN after the last read.
  - DRAIN -> DONE once the delay line is empty.
  - DONE -> IDLE unconditionally (one cycle).
- READ phase:
  - Runs for cycles 1 .. N, with N = (num_tiles+1)*(num_row+1).
  - Row counter r runs 0..num_row; tile counter t increments when r wraps. No gap between tiles.
  - weightMem_rd_en[c] = 1 for c <= num_col, 0 otherwise.
  - Active columns share one address: base_addr + t*tile_stride + r, computed modulo 2^ADDR_WIDTH (wraps silently).
  - The address field of an inactive column is 0.
  - Implementation: accumulate tile_base += tile_stride; no multiplier.
- fifo_active is the OR of READ-phase rd_en, delayed MEM_LAT cycles. It is high for cycles 1+MEM_LAT .. N+MEM_LAT.
- done is high at cycle N+MEM_LAT+1 (the DONE state). busy is high from cycle 1 through cycle N+MEM_LAT; done and busy are never high together.
- start while not IDLE: ignored, including a start in the DONE cycle.
- start in the same cycle as done: not accepted; the master must re-issue it.
- abort (any non-IDLE state) -> IDLE next edge:
  - rd_en and the delay line are cleared; fifo_active is 0 from the next cycle.
  - No done pulse.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins, start is dropped.
- Degenerate case num_row=0, num_tiles=0: N=1, a single read cycle.

Optional Feature:
Macro STAGGER_FILL_EN.
- Defined: column c's rd_en and address are delayed c cycles through a per-column skew register (diagonal load, matching the systolic input skew).
- fifo_active covers the union window, cycles 1+MEM_LAT .. N+num_col+MEM_LAT.
- done moves to N+num_col+MEM_LAT+1; busy extends to match. abort clears the skew registers too.
- Undefined: all columns are aligned as described above and there is no skew logic.

Decomposition:
- Shared package fill_pkg:
  - state enum (IDLE, READ, DRAIN, DONE);
  - localparams for the row/col counter widths derived via $clog2;
  - helper function col_addr_slice(c).
- Sub-module valid_delay_line (parameters DEPTH, WIDTH; async active-low reset, synchronous clear). Used for the MEM_LAT fifo_active delay, and per column for stagger skew when STAGGER_FILL_EN is defined.

Test Plan:
- num_row=15, num_col=15, num_tiles=0, base_addr=12, MEM_LAT=1, start at cycle 0 -> rd_en=16'hFFFF cycles 1-16, addresses 12..27, fifo_active cycles 2-17, done at 18 only.
- num_row=3, num_col=3, num_tiles=1, base_addr=250, tile_stride=32 -> rd_en=16'h000F, addresses 250,251,252,253,26,27,28,29, inactive address fields 0, done at cycle 10.
- Same as the first scenario; start re-pulsed at cycle 5 and at the done cycle -> ignored; exactly one done, then IDLE.
- abort at cycle 6 of the first scenario -> rd_en=0 from cycle 7, fifo_active=0 from cycle 7, busy=0, no done; a new start at cycle 10 completes normally.
- reset driven low asynchronously mid-READ (between edges) -> all outputs 0 immediately; after release, outputs stay 0 until the next start.
- STAGGER_FILL_EN, num_row=0, num_col=3, num_tiles=0 -> rd_en[c] high only at cycle 1+c, fifo_active cycles 2-5, done at cycle 6.

Source files
------------

// File: rtl/fill_pkg.sv
// fill_pkg: shared state encoding, default geometry and column slicing for weight_fill_sequencer.
package fill_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} fill_state_e;
  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int ROW_CNT_W = $clog2(DEF_ROWS);
  localparam int COL_CNT_W = $clog2(DEF_COLS);
  function automatic int col_addr_slice(input int c, input int aw = DEF_ADDR_W);
    return c * aw;
  endfunction
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-stage shift register (DEPTH >= 1), async active-low reset, synchronous clear.
module valid_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_pipe [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pipe <= '{default: '0};
    else if (i_clr) r_pipe <= '{default: '0};
    else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/weight_fill_sequencer.sv
// weight_fill_sequencer: multi-tile per-column weight memory read sequencer with latency-aligned fifo_active.
// Define STAGGER_FILL_EN to skew column c by c cycles (diagonal load).
module weight_fill_sequencer
  import fill_pkg::*;
#(
  parameter int SYS_ARR_ROWS = DEF_ROWS,
  parameter int SYS_ARR_COLS = DEF_COLS,
  parameter int ADDR_WIDTH   = DEF_ADDR_W,
  parameter int TILE_WIDTH   = 4,
  parameter int MEM_LAT      = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [$clog2(SYS_ARR_ROWS)-1:0]    num_row,
  input  logic [$clog2(SYS_ARR_COLS)-1:0]    num_col,
  input  logic [TILE_WIDTH-1:0]              num_tiles,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH-1:0]              tile_stride,
  output logic [SYS_ARR_COLS-1:0]            weightMem_rd_en,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] weightMem_rd_addr,
  output logic                               fifo_active,
  output logic                               busy,
  output logic                               done
);
  localparam int RW = $clog2(SYS_ARR_ROWS);
  localparam int CW = $clog2(SYS_ARR_COLS);
  localparam int DW = $clog2(MEM_LAT + SYS_ARR_COLS + 1);
  fill_state_e r_state, w_nxt;
  logic [RW-1:0] r_row, r_cfg_row;
  logic [CW-1:0] r_cfg_col;
  logic [TILE_WIDTH-1:0] r_tile, r_cfg_tiles;
  logic [ADDR_WIDTH-1:0] r_tile_base, r_cfg_stride, w_addr;
  logic [DW-1:0] r_drain, w_drain_len;
  logic [SYS_ARR_COLS-1:0] w_en;
  logic w_row_wrap, w_last, w_accept, w_clr;
  assign w_row_wrap = r_row == r_cfg_row;
  assign w_last     = w_row_wrap && r_tile == r_cfg_tiles;
  assign w_accept   = r_state == IDLE && start && !abort;
  assign w_clr      = abort && r_state != IDLE;
  assign w_addr     = r_tile_base + ADDR_WIDTH'(r_row);
`ifdef STAGGER_FILL_EN
  assign w_drain_len = DW'(MEM_LAT - 1) + DW'(r_cfg_col);
`else
  assign w_drain_len = DW'(MEM_LAT - 1);
`endif
  always_comb begin
    w_nxt = r_state;
    if (r_state == IDLE) w_nxt = w_accept ? READ : IDLE;
    else if (abort) w_nxt = IDLE;
    else if (r_state == READ) w_nxt = w_last ? DRAIN : READ;
    else if (r_state == DRAIN) w_nxt = r_drain == '0 ? DONE : DRAIN;
    else w_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_tile       <= '0;
      r_tile_base  <= '0;
      r_drain      <= '0;
      r_cfg_row    <= '0;
      r_cfg_col    <= '0;
      r_cfg_tiles  <= '0;
      r_cfg_stride <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_cfg_row    <= num_row;
        r_cfg_col    <= num_col;
        r_cfg_tiles  <= num_tiles;
        r_cfg_stride <= tile_stride;
        r_tile_base  <= base_addr;
        r_row        <= '0;
        r_tile       <= '0;
      end else if (r_state == READ) begin
        r_row <= w_row_wrap ? '0 : r_row + RW'(1);
        if (w_row_wrap) begin
          r_tile      <= r_tile + TILE_WIDTH'(1);
          r_tile_base <= r_tile_base + r_cfg_stride;
        end
      end
      // drain length is loaded every READ cycle so the last one leaves the right count
      r_drain <= r_state == READ ? w_drain_len : r_drain - DW'(r_state == DRAIN && r_drain != '0);
    end
  for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_col
    logic [ADDR_WIDTH-1:0] w_field;
    assign w_en[c]  = r_state == READ && CW'(c) <= r_cfg_col;
    assign w_field  = w_en[c] ? w_addr : '0;
`ifdef STAGGER_FILL_EN
    if (c == 0) begin : g_direct
      assign weightMem_rd_en[c] = w_en[c];
      assign weightMem_rd_addr[col_addr_slice(c, ADDR_WIDTH) +: ADDR_WIDTH] = w_field;
    end else begin : g_skew
      valid_delay_line #(.DEPTH(c), .WIDTH(ADDR_WIDTH + 1)) u_skew (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (w_clr),
        .i_d   ({w_en[c], w_field}),
        .o_q   ({weightMem_rd_en[c], weightMem_rd_addr[col_addr_slice(c, ADDR_WIDTH) +: ADDR_WIDTH]})
      );
    end
`else
    assign weightMem_rd_en[c] = w_en[c];
    assign weightMem_rd_addr[col_addr_slice(c, ADDR_WIDTH) +: ADDR_WIDTH] = w_field;
`endif
  end
  valid_delay_line #(.DEPTH(MEM_LAT), .WIDTH(1)) u_lat (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_clr),
    .i_d   (|weightMem_rd_en),
    .o_q   (fifo_active)
  );
  assign busy = r_state == READ || r_state == DRAIN;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_weight_fill_sequencer.sv
// tb_weight_fill_sequencer: closed-form reference model with per-cycle compare plus directed literal checks.
module tb_weight_fill_sequencer;
  localparam int ROWS = 16, COLS = 16, AW = 8, TW = 4, LAT = 1;
`ifdef STAGGER_FILL_EN
  localparam bit STAG = 1;
`else
  localparam bit STAG = 0;
`endif
  logic clk = 0, reset = 0, start = 0, abort = 0;
  logic [3:0] num_row = 0, num_col = 0;
  logic [TW-1:0] num_tiles = 0;
  logic [AW-1:0] base_addr = 0, tile_stride = 0;
  logic [COLS-1:0] rd_en;
  logic [COLS*AW-1:0] rd_addr;
  logic fifo_active, busy, done;
  int checks = 0, errors = 0;
  bit m_active = 0;
  int m_cyc = 0, m_s = 0, c_row = 0, c_col = 0, c_tiles = 0, c_base = 0, c_stride = 0;

  weight_fill_sequencer #(.SYS_ARR_ROWS(ROWS), .SYS_ARR_COLS(COLS), .ADDR_WIDTH(AW),
    .TILE_WIDTH(TW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_row(num_row),
    .num_col(num_col), .num_tiles(num_tiles), .base_addr(base_addr), .tile_stride(tile_stride),
    .weightMem_rd_en(rd_en), .weightMem_rd_addr(rd_addr), .fifo_active(fifo_active),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic int done_rel();
    return (c_tiles + 1) * (c_row + 1) + (STAG ? c_col : 0) + LAT + 1;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) m_active = 0;
    else begin
      if (m_active) begin
        if (abort || m_cyc - m_s == done_rel()) m_active = 0;
      end else if (start && !abort) begin
        m_active = 1; m_s = m_cyc;
        c_row = num_row; c_col = num_col; c_tiles = num_tiles; c_base = base_addr; c_stride = tile_stride;
      end
      m_cyc++;
    end

  task automatic model_out(output logic [COLS-1:0] en, output logic [COLS*AW-1:0] ad,
                           output logic fa, output logic bz, output logic dn);
    int rel, n, span, j;
    en = '0; ad = '0; fa = 0; bz = 0; dn = 0;
    if (m_active) begin
      rel = m_cyc - m_s;
      n = (c_tiles + 1) * (c_row + 1);
      span = STAG ? c_col : 0;
      for (int c = 0; c < COLS; c++) begin
        j = rel - 1 - (STAG ? c : 0);
        if (c <= c_col && j >= 0 && j < n) begin
          en[c] = 1;
          ad[c*AW +: AW] = AW'(c_base + (j / (c_row + 1)) * c_stride + j % (c_row + 1));
        end
      end
      fa = rel >= 1 + LAT && rel <= n + span + LAT;
      bz = rel >= 1 && rel <= n + span + LAT;
      dn = rel == n + span + LAT + 1;
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t cyc=%0d got=%0h want=%0h", nm, $time, m_cyc, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      logic [COLS-1:0] e_en;
      logic [COLS*AW-1:0] e_ad;
      logic e_fa, e_bz, e_dn;
      model_out(e_en, e_ad, e_fa, e_bz, e_dn);
      chk("rd_en", rd_en, e_en);
      chk("rd_addr", rd_addr, e_ad);
      chk("fifo_active", fifo_active, e_fa);
      chk("busy", busy, e_bz);
      chk("done", done, e_dn);
    end

  task automatic cfg(input int r, input int c, input int t, input int b, input int s);
    num_row = 4'(r); num_col = 4'(c); num_tiles = TW'(t); base_addr = AW'(b); tile_stride = AW'(s);
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic go();
    @(negedge clk);
    pulse_start();
  endtask

  task automatic wait_rel(input int k);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (m_cyc - m_s == k) return;
    end
    checks++; errors++;
    $display("FAIL wait_rel timeout got=%0d want=%0d", m_cyc - m_s, k);
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_en"}, rd_en, 0);
    chk({nm, "_addr"}, rd_addr, 0);
    chk({nm, "_fa"}, fifo_active, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    int dr;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dr;
    #12 all_zero("reset");
    @(negedge clk) reset = 1;
    repeat (2) @(negedge clk);
    // full 16x16 single tile
    cfg(15, 15, 0, 12, 0); go();
    wait_rel(1);  chk("s1_en1", rd_en, 16'hFFFF); chk("s1_a1", rd_addr[7:0], 12); chk("s1_a1c15", rd_addr[127:120], 12);
    wait_rel(16); chk("s1_a16", rd_addr[7:0], 27);
    wait_rel(17); chk("s1_en17", rd_en, 0); chk("s1_fa17", fifo_active, 1);
    if (!STAG) begin
      wait_rel(18); chk("s1_done18", done, 1); chk("s1_busy18", busy, 0);
    end
    wait_rel(done_rel() + 1); chk("s1_after_done", done, 0);
    // two tiles with address wrap; inputs scrambled after acceptance
    cfg(3, 3, 1, 250, 32); go();
    cfg(0, 15, 0, 0, 1);
    wait_rel(1); chk("s2_a1", rd_addr[7:0], 250);
    wait_rel(5); chk("s2_a5", rd_addr[7:0], 26); chk("s2_en5", rd_en, 16'h000F);
    chk("s2_inactive", rd_addr[39:32], 0);
    if (!STAG) chk("s2_a5c3", rd_addr[31:24], 26);
    wait_rel(8); chk("s2_a8", rd_addr[7:0], 29);
    if (!STAG) begin
      wait_rel(10); chk("s2_done10", done, 1);
    end
    wait_rel(done_rel() + 2);
    // start re-pulsed mid-run and in the done cycle
    cfg(15, 15, 0, 12, 0); go();
    wait_rel(5); pulse_start();
    dr = done_rel();
    wait_rel(dr); chk("s3_done", done, 1); pulse_start();
    for (int k = 1; k <= 3; k++) begin
      wait_rel(dr + k); chk("s3_no_done", done, 0); chk("s3_idle", busy, 0);
    end
    // abort at cycle 6, restart at cycle 10
    go();
    wait_rel(6); abort = 1; @(posedge clk); #1 abort = 0;
    wait_rel(7); chk("s4_en7", rd_en, 0); chk("s4_fa7", fifo_active, 0); chk("s4_busy7", busy, 0);
    wait_rel(10); pulse_start();
    dr = done_rel();
    wait_rel(dr); chk("s4_restart_done", done, 1);
    wait_rel(dr + 2);
    // abort and start together in IDLE
    @(negedge clk); start = 1; abort = 1; @(posedge clk); #1 start = 0; abort = 0;
    @(negedge clk); chk("s5_busy", busy, 0); chk("s5_en", rd_en, 0);
    // asynchronous reset mid-READ
    go();
    wait_rel(6); chk("s6_busy6", busy, 1);
    #2 reset = 0;
    #1 all_zero("s6_async");
    @(negedge clk); #1 reset = 1;
    repeat (4) @(negedge clk);
    chk("s6_post_busy", busy, 0); chk("s6_post_en", rd_en, 0);
    // degenerate single read
    cfg(0, 0, 0, 7, 5); go();
    wait_rel(1); chk("s7_en", rd_en, 16'h0001); chk("s7_addr", rd_addr[7:0], 7);
    wait_rel(2); chk("s7_en2", rd_en, 0); chk("s7_fa2", fifo_active, 1);
    wait_rel(3); chk("s7_done", done, 1);
    wait_rel(5);
    // four columns, one row: diagonal when staggered, aligned otherwise
    cfg(0, 3, 0, 40, 0); go();
    wait_rel(1);
    if (STAG) begin
      chk("s8_en1", rd_en, 16'h0001);
      wait_rel(2); chk("s8_en2", rd_en, 16'h0002); chk("s8_a2c1", rd_addr[15:8], 40); chk("s8_a2c0", rd_addr[7:0], 0);
      wait_rel(4); chk("s8_en4", rd_en, 16'h0008);
      wait_rel(5); chk("s8_en5", rd_en, 0); chk("s8_fa5", fifo_active, 1);
      wait_rel(6); chk("s8_done6", done, 1);
    end else begin
      chk("s8_en1", rd_en, 16'h000F); chk("s8_a1c3", rd_addr[31:24], 40);
      wait_rel(3); chk("s8_done3", done, 1);
    end
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
